fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single write port of one fifo instance among NUM_REQ producers.
//   Each producer offers words on a valid/ready handshake and holds the grant for a burst of up to MAX_BURST words.
//   The block sits directly in front of the fifo write side: o_fifo_wr_en/o_fifo_data drive i_wr_en/i_data, and
//   o_fifo_full feeds i_fifo_full.
// PARAMETERS
//   NUM_REQ    4  number of requesters (>=2)
//   SIZE_DATA  8  data word width; matches fifo SIZE_DATA
//   MAX_BURST  4  max words per grant before forced release (>=1)
// PORTS
//   i_clk         in   1                   clock
//   i_rst_n       in   1                   reset, synchronous, active low
//   i_req_valid   in   NUM_REQ             per-requester word valid
//   i_req_last    in   NUM_REQ             per-requester last word of burst, qualified by valid
//   i_req_data    in   NUM_REQ*SIZE_DATA   requester k data in bits [k*SIZE_DATA +: SIZE_DATA]
//   o_req_ready   out  NUM_REQ             per-requester ready, one-hot or zero
//   i_fifo_full   in   1                   fifo full flag
//   o_fifo_wr_en  out  1                   fifo write strobe
//   o_fifo_data   out  SIZE_DATA           fifo write data
//   o_grant_id    out  $clog2(NUM_REQ)     index of current or last owner (registered)
//   o_busy        out  1                   high while a grant is held
// BEHAVIOUR
//   Reset (i_rst_n low at posedge):
//     state=IDLE, beat_cnt=0, o_grant_id=0, last_ptr=NUM_REQ-1, so requester 0 wins first.
//     o_req_ready, o_fifo_wr_en and o_busy are 0 from the same edge; o_fifo_data is 0.
//     Reset mid-burst aborts the burst; no write is issued in the reset cycle.
//   FSM IDLE:
//     If any i_req_valid, pick the first valid index searching last_ptr+1, +2, ... modulo NUM_REQ.
//     Register it into o_grant_id, clear beat_cnt, go to GRANT.
//     Arbitration costs exactly 1 cycle; no ready in IDLE.
//   FSM GRANT, g = o_grant_id:
//     o_req_ready[g] = ~i_fifo_full (combinational); all other ready bits are 0.
//     xfer = i_req_valid[g] & o_req_ready[g].
//     o_fifo_wr_en = xfer; o_fifo_data = word g (combinational mux, 0 when not GRANT).
//     On xfer, beat_cnt increments.
//     Release (go to IDLE, last_ptr <= g) when any of:
//       (a) xfer with i_req_last[g];
//       (b) xfer with beat_cnt == MAX_BURST-1;
//       (c) i_req_valid[g] low while i_fifo_full low (producer idle).
//   Full handling: i_fifo_full high holds the grant indefinitely.
//     No write, beat_cnt frozen, rule (c) suppressed.
//   o_busy = (state == GRANT). o_grant_id holds its value in IDLE until the next pick.
//   Throughput: a burst of B words takes B cycles plus 1 arbitration bubble.
//     A single active requester is re-granted after each bubble.
//   Widths: beat_cnt is $clog2(MAX_BURST+1) bits; last_ptr wraps NUM_REQ-1 -> 0 with no out-of-range index.
//   Simultaneous new valids during GRANT are not sampled until IDLE; fairness is per burst, not per word.
// TESTING
//   1) Reset mid-burst: req0 granted after 2 of 4 words, pulse rst_n low 1 cycle.
//      -> wr_en/ready/busy 0 that edge; next pick is req0.
//   2) All 4 valid, no last, MAX_BURST=4, fifo never full.
//      -> grant order 0,1,2,3,0; 4 writes each; 16 writes in 20 cycles.
//   3) Only req2 valid, last on beat 2.
//      -> 2 writes, 1-cycle bubble, req2 re-granted, o_grant_id=2 throughout.
//   4) Req1 bursting, i_fifo_full high 3 cycles after beat 1.
//      -> ready1=0, wr_en=0 for 3 cycles, grant held, burst completes with 4 total writes.
//   5) Req1 drops valid after 1 beat, req0 and req3 valid.
//      -> release; next grant goes to req3 (search from 2), then req0.
//   6) With fifo SIZE_DEPTH=8: req0 and req1 each push 0x10..0x17 sequences.
//      -> exactly 8 writes accepted, then full stalls.
//      -> popping yields words in grant order with no loss or duplication.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ valid/ready producers,
// each holding the grant for a burst of up to MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SIZE_DATA = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0]             i_req_last,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic                           i_fifo_full,
    output logic                           o_fifo_wr_en,
    output logic [SIZE_DATA-1:0]           o_fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
    output logic                           o_busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_nxt;
    logic [ID_W-1:0] grant_nxt;
    logic [ID_W-1:0] last_ptr;
    logic [ID_W-1:0] last_nxt;

    logic [ID_W-1:0]      pick_idx;
    logic                 pick_found;
    int unsigned          cand;
    logic [SIZE_DATA-1:0] word_g;
    logic                 ready_g;
    logic                 xfer;

    // Round-robin search starting one past the previous owner.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(last_ptr) + i) % NUM_REQ;
            if (!pick_found && i_req_valid[ID_W'(cand)]) begin
                pick_idx   = ID_W'(cand);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        word_g = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == o_grant_id) begin
                word_g = i_req_data[k*SIZE_DATA +: SIZE_DATA];
            end
        end
    end

    // Next-state and handshake outputs; outputs are forced low during a reset cycle.
    always_comb begin
        state_nxt    = state;
        beat_nxt     = beat_cnt;
        grant_nxt    = o_grant_id;
        last_nxt     = last_ptr;
        o_req_ready  = '0;
        o_fifo_wr_en = 1'b0;
        o_fifo_data  = '0;
        ready_g      = 1'b0;
        xfer         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    grant_nxt = pick_idx;
                    beat_nxt  = '0;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (i_rst_n) begin
                    ready_g     = ~i_fifo_full;
                    o_fifo_data = word_g;
                end
                o_req_ready[o_grant_id] = ready_g;
                xfer         = i_req_valid[o_grant_id] & ready_g;
                o_fifo_wr_en = xfer;
                if (xfer) begin
                    beat_nxt = beat_cnt + CNT_W'(1);
                    if (i_req_last[o_grant_id] || (beat_cnt == CNT_W'(MAX_BURST - 1))) begin
                        state_nxt = ST_IDLE;
                        last_nxt  = o_grant_id;
                    end
                end else if (!i_req_valid[o_grant_id] && !i_fifo_full) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = o_grant_id;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            o_grant_id <= '0;
            last_ptr   <= ID_W'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_nxt;
            o_grant_id <= grant_nxt;
            last_ptr   <= last_nxt;
        end
    end

    assign o_busy = (state == ST_GRANT);

endmodule
